// File: rtl/sparse_pe_pkg.sv
// Shared defaults, pass-state encoding and saturating arithmetic helpers for the sparse PE.
package sparse_pe_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_C_W    = 5;
  localparam int unsigned DEF_IA_MAX = 8;
  localparam int unsigned DEF_NUM_K  = 4;
  localparam int unsigned DEF_NUM_R  = 3;
  localparam int unsigned DEF_ACC_W  = 40;
  localparam int unsigned DEF_FRAC   = 8;

  // Helpers work on a fixed wide signed word; callers sign-extend in and truncate out.
  localparam int unsigned WIDE_W = 64;
  localparam int unsigned SUM_W  = WIDE_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_OUT
  } state_t;

  function automatic logic signed [WIDE_W-1:0] sat_add(
    input logic signed [WIDE_W-1:0] a,
    input logic signed [WIDE_W-1:0] b,
    input int unsigned              w
  );
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    sum = SUM_W'(a) + SUM_W'(b);
    hi  = (SUM_W'(1) <<< (w - 1)) - SUM_W'(1);
    lo  = -(SUM_W'(1) <<< (w - 1));
    if (sum > hi) return WIDE_W'(hi);
    if (sum < lo) return WIDE_W'(lo);
    return WIDE_W'(sum);
  endfunction

  function automatic logic signed [WIDE_W-1:0] sat_shift_relu(
    input logic signed [WIDE_W-1:0] acc,
    input int unsigned              frac,
    input int unsigned              w,
    input logic                     relu
  );
    logic signed [WIDE_W-1:0] v;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    v  = acc >>> frac;
    hi = (WIDE_W'(1) <<< (w - 1)) - WIDE_W'(1);
    lo = -(WIDE_W'(1) <<< (w - 1));
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    if (relu && (v < 0)) v = '0;
    return v;
  endfunction

endpackage

// File: rtl/ia_lookup_table.sv
// Dense channel-indexed table of the latched IA pixel: bulk write on start, one combinational read.
module ia_lookup_table
  import sparse_pe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned C_W    = DEF_C_W,
  parameter int unsigned IA_MAX = DEF_IA_MAX,
  parameter int unsigned LEN_W  = $clog2(DEF_IA_MAX) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [IA_MAX-1:0][DATA_W-1:0]  wr_data,
  input  logic [IA_MAX-1:0][C_W-1:0]     wr_c_idx,
  input  logic [LEN_W-1:0]               wr_len,
  input  logic [C_W-1:0]                 rd_c_idx,
  output logic                           rd_hit,
  output logic [DATA_W-1:0]              rd_data
);

  localparam int unsigned DEPTH = 1 << C_W;

  logic              present [DEPTH];
  logic [DATA_W-1:0] data    [DEPTH];

  // Later loop iterations override earlier ones, so the higher entry wins on duplicates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < int'(DEPTH); d++) present[d] <= 1'b0;
    end else if (wr_en) begin
      for (int d = 0; d < int'(DEPTH); d++) present[d] <= 1'b0;
      for (int i = 0; i < int'(IA_MAX); i++) begin
        if (LEN_W'(i) < wr_len) begin
          present[wr_c_idx[i]] <= 1'b1;
          data[wr_c_idx[i]]    <= wr_data[i];
        end
      end
    end
  end

  assign rd_hit  = present[rd_c_idx];
  assign rd_data = data[rd_c_idx];

endmodule

// File: rtl/sparse_pe_mac.sv
// Sparse PE: channel-matched multiply-accumulate of a weight stream against one IA pixel,
// with optional cross-pass accumulation, saturating rescale and ReLU at the output.
module sparse_pe_mac
  import sparse_pe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned C_W    = DEF_C_W,
  parameter int unsigned IA_MAX = DEF_IA_MAX,
  parameter int unsigned NUM_K  = DEF_NUM_K,
  parameter int unsigned NUM_R  = DEF_NUM_R,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned FRAC   = DEF_FRAC
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_start,
  input  logic                                 i_accum,
  input  logic                                 i_relu,
  input  logic [IA_MAX-1:0][DATA_W-1:0]        i_ia_data,
  input  logic [IA_MAX-1:0][C_W-1:0]           i_ia_c_idx,
  input  logic [$clog2(IA_MAX):0]              i_ia_len,
  input  logic                                 i_w_valid,
  output logic                                 o_w_ready,
  input  logic [DATA_W-1:0]                    i_w_data,
  input  logic [C_W-1:0]                       i_w_c_idx,
  input  logic [$clog2(NUM_K)-1:0]             i_w_k,
  input  logic [$clog2(NUM_R)-1:0]             i_w_r,
  input  logic                                 i_w_last,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic [NUM_K*NUM_R-1:0][DATA_W-1:0]   o_out
);

  localparam int unsigned NUM_OUT = NUM_K * NUM_R;
  localparam int unsigned ADDR_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int unsigned PROD_W  = 2 * DATA_W;
  localparam int unsigned LEN_W   = $clog2(IA_MAX) + 1;

  state_t                    state;
  logic                      relu_q;
  logic                      start_go;
  logic                      accept;
  logic                      hit;
  logic                      in_range;
  logic [DATA_W-1:0]         ia_val;
  logic                      mac_vld;
  logic [ADDR_W-1:0]         mac_addr;
  logic signed [PROD_W-1:0]  mac_prod;
  logic signed [ACC_W-1:0]   acc     [NUM_OUT];
  logic signed [ACC_W-1:0]   acc_nxt [NUM_OUT];

  assign start_go = (state == ST_IDLE) && i_start;
  assign accept   = i_w_valid && o_w_ready;
  assign in_range = (32'(i_w_k) < NUM_K) && (32'(i_w_r) < NUM_R);

  ia_lookup_table #(
    .DATA_W (DATA_W),
    .C_W    (C_W),
    .IA_MAX (IA_MAX),
    .LEN_W  (LEN_W)
  ) u_table (
    .clk      (i_clk),
    .rst      (i_rst),
    .wr_en    (start_go),
    .wr_data  (i_ia_data),
    .wr_c_idx (i_ia_c_idx),
    .wr_len   (i_ia_len),
    .rd_c_idx (i_w_c_idx),
    .rd_hit   (hit),
    .rd_data  (ia_val)
  );

  // Pass sequencing; busy/ready/done are registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      o_busy    <= 1'b0;
      o_w_ready <= 1'b0;
      o_done    <= 1'b0;
      relu_q    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        ST_IDLE: if (i_start) begin
          state     <= ST_STREAM;
          o_busy    <= 1'b1;
          o_w_ready <= 1'b1;
          relu_q    <= i_relu;
        end
        ST_STREAM: if (accept && i_w_last) begin
          state     <= ST_DRAIN;
          o_w_ready <= 1'b0;
        end
        ST_DRAIN: begin
          state  <= ST_OUT;
          o_done <= 1'b1;
        end
        ST_OUT: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Single add per cycle into the registered address.
  always_comb begin
    for (int i = 0; i < int'(NUM_OUT); i++) begin
      acc_nxt[i] = acc[i];
      if (mac_vld && (mac_addr == ADDR_W'(i)))
        acc_nxt[i] = ACC_W'(sat_add(WIDE_W'(acc[i]), WIDE_W'(mac_prod), ACC_W));
    end
  end

  // Outputs are taken from acc_nxt so the last add lands in the same edge as done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mac_vld  <= 1'b0;
      mac_addr <= '0;
      mac_prod <= '0;
      o_out    <= '0;
      for (int i = 0; i < int'(NUM_OUT); i++) acc[i] <= '0;
    end else begin
      mac_vld  <= accept && hit && in_range;
      mac_addr <= ADDR_W'(int'(i_w_k) * int'(NUM_R) + int'(i_w_r));
      mac_prod <= PROD_W'($signed(ia_val)) * PROD_W'($signed(i_w_data));
      for (int i = 0; i < int'(NUM_OUT); i++)
        acc[i] <= (start_go && !i_accum) ? '0 : acc_nxt[i];
      if (state == ST_DRAIN) begin
        for (int i = 0; i < int'(NUM_OUT); i++)
          o_out[i] <= DATA_W'(sat_shift_relu(WIDE_W'(acc_nxt[i]), FRAC, DATA_W, relu_q));
      end
    end
  end

endmodule
